// File: rtl/epu_dpcm_pkg.sv
// Shared definitions for the EPU forward and inverse DC DPCM paths.
// Channel tags and the default block count per channel.
package epu_dpcm_pkg;

   typedef logic [1:0] dpcm_mode_t;

   localparam dpcm_mode_t MODE_NONE = 2'b00;
   localparam dpcm_mode_t MODE_Y    = 2'b01;
   localparam dpcm_mode_t MODE_CR   = 2'b10;
   localparam dpcm_mode_t MODE_CB   = 2'b11;

   localparam int BLOCKS_DEF = 64;

   typedef enum logic {
      PH_FIRST,
      PH_REST
   } dpcm_phase_t;

endpackage

// File: rtl/idpcm_chan.sv
// One channel of the inverse DC DPCM: phase, block counter and base.
// dc/last are combinational views of the effective (post-clear) state.
module idpcm_chan
   import epu_dpcm_pkg::*;
#(
   parameter int BLOCKS = BLOCKS_DEF,
   parameter int DW     = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          accept,
   input  logic [DW-1:0] diff,
   output logic [DW-1:0] dc,
   output logic          last
);

   localparam int CW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(BLOCKS - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   dpcm_phase_t   phase_q, phase_d, phase_e;
   logic [CW-1:0] cnt_q, cnt_d, cnt_e;
   logic [DW-1:0] base_q, base_d, base_e;

   // Clear wins first, then the accept is applied on top of it.
   always_comb begin
      phase_e = clear ? PH_FIRST : phase_q;
      cnt_e   = clear ? '0 : cnt_q;
      base_e  = clear ? '0 : base_q;
      last    = (cnt_e == LAST_IDX);
      dc      = (phase_e == PH_FIRST) ? diff : base_e - diff;
      phase_d = phase_e;
      cnt_d   = cnt_e;
      base_d  = base_e;
      if (accept) begin
         if (phase_e == PH_FIRST) begin
            base_d = diff;
         end
         if (last) begin
            phase_d = PH_FIRST;
            cnt_d   = '0;
         end else begin
            phase_d = PH_REST;
            cnt_d   = cnt_e + ONE;
         end
      end
   end

   // Channel state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= PH_FIRST;
         cnt_q   <= '0;
         base_q  <= '0;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
      end
   end

endmodule

// File: rtl/idpcm_dc.sv
// Inverse DC DPCM for Y/Cr/Cb: three channel trackers, a mode
// decoder and a registered output stage.
module idpcm_dc
   import epu_dpcm_pkg::*;
#(
   parameter int BLOCKS = BLOCKS_DEF,
   parameter int DW     = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] diff_in,
   input  logic          diff_valid,
   output logic [DW-1:0] dc_out,
   output logic          dc_valid,
   output logic [1:0]    dc_mode,
   output logic          dc_last,
   output logic          mode_err
);

   logic          acc_y, acc_cr, acc_cb;
   logic [DW-1:0] dc_y, dc_cr, dc_cb;
   logic          last_y, last_cr, last_cb;

   logic [DW-1:0] dc_d, dc_q;
   logic          vld_d, vld_q;
   dpcm_mode_t    mode_d, mode_q;
   logic          last_d, last_q;
   logic          err_d, err_q;

   idpcm_chan #(.BLOCKS(BLOCKS), .DW(DW)) u_y (
      .clk    (clk),
      .rst    (rst),
      .clear  (frame_start),
      .accept (acc_y),
      .diff   (diff_in),
      .dc     (dc_y),
      .last   (last_y)
   );

   idpcm_chan #(.BLOCKS(BLOCKS), .DW(DW)) u_cr (
      .clk    (clk),
      .rst    (rst),
      .clear  (frame_start),
      .accept (acc_cr),
      .diff   (diff_in),
      .dc     (dc_cr),
      .last   (last_cr)
   );

   idpcm_chan #(.BLOCKS(BLOCKS), .DW(DW)) u_cb (
      .clk    (clk),
      .rst    (rst),
      .clear  (frame_start),
      .accept (acc_cb),
      .diff   (diff_in),
      .dc     (dc_cb),
      .last   (last_cb)
   );

   // Decode the channel tag and select the addressed channel's result.
   always_comb begin
      acc_y  = 1'b0;
      acc_cr = 1'b0;
      acc_cb = 1'b0;
      dc_d   = dc_q;
      vld_d  = 1'b0;
      mode_d = mode_q;
      last_d = last_q;
      err_d  = 1'b0;
      if (diff_valid) begin
         unique case (mode)
            MODE_Y: begin
               acc_y  = 1'b1;
               dc_d   = dc_y;
               last_d = last_y;
            end
            MODE_CR: begin
               acc_cr = 1'b1;
               dc_d   = dc_cr;
               last_d = last_cr;
            end
            MODE_CB: begin
               acc_cb = 1'b1;
               dc_d   = dc_cb;
               last_d = last_cb;
            end
            default: begin
               err_d = 1'b1;
            end
         endcase
         if (mode != MODE_NONE) begin
            vld_d  = 1'b1;
            mode_d = mode;
         end
      end
   end

   // Output register; data fields hold between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dc_q   <= '0;
         vld_q  <= 1'b0;
         mode_q <= MODE_NONE;
         last_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         dc_q   <= dc_d;
         vld_q  <= vld_d;
         mode_q <= mode_d;
         last_q <= last_d;
         err_q  <= err_d;
      end
   end

   assign dc_out   = dc_q;
   assign dc_valid = vld_q;
   assign dc_mode  = mode_q;
   assign dc_last  = last_q;
   assign mode_err = err_q;

endmodule

// File: tb/tb_idpcm_dc.sv
// Bench for idpcm_dc: directed vectors, a per-channel reference
// model and a per-cycle output compare.
module tb_idpcm_dc;

   localparam int BLOCKS = 64;
   localparam int DW     = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          frame_start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [DW-1:0] diff_in = '0;
   logic          diff_valid = 1'b0;
   logic [DW-1:0] dc_out;
   logic          dc_valid;
   logic [1:0]    dc_mode;
   logic          dc_last;
   logic          mode_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   int            mcnt [4];
   logic [DW-1:0] mbase [4];

   logic [DW-1:0] exp_dc   = '0;
   logic          exp_vld  = 1'b0;
   logic [1:0]    exp_mode = 2'b00;
   logic          exp_last = 1'b0;
   logic          exp_err  = 1'b0;

   idpcm_dc #(.BLOCKS(BLOCKS), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .mode        (mode),
      .diff_in     (diff_in),
      .diff_valid  (diff_valid),
      .dc_out      (dc_out),
      .dc_valid    (dc_valid),
      .dc_mode     (dc_mode),
      .dc_last     (dc_last),
      .mode_err    (mode_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, want,
                  $time);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < 4; c++) begin
         mcnt[c]  = 0;
         mbase[c] = '0;
      end
   endtask

   task automatic exp_zero();
      exp_dc   = '0;
      exp_vld  = 1'b0;
      exp_mode = 2'b00;
      exp_last = 1'b0;
      exp_err  = 1'b0;
   endtask

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("dc_valid", 32'(dc_valid), 32'(exp_vld));
         check("dc_out", 32'(dc_out), 32'(exp_dc));
         check("dc_mode", 32'(dc_mode), 32'(exp_mode));
         check("dc_last", 32'(dc_last), 32'(exp_last));
         check("mode_err", 32'(mode_err), 32'(exp_err));
      end
   end

   task automatic send(input logic fs, input logic v,
                       input logic [1:0] m, input logic [DW-1:0] d);
      logic [DW-1:0] p_dc;
      logic          p_vld, p_last, p_err;
      logic [1:0]    p_mode;
      int            c;
      logic          lst;
      @(negedge clk);
      frame_start = fs;
      diff_valid  = v;
      mode        = m;
      diff_in     = d;
      if (fs) model_clear();
      p_dc   = exp_dc;
      p_mode = exp_mode;
      p_last = exp_last;
      p_vld  = 1'b0;
      p_err  = 1'b0;
      c      = int'(m);
      if (v && m != 2'b00) begin
         lst = (mcnt[c] == BLOCKS - 1);
         if (mcnt[c] == 0) begin
            p_dc     = d;
            mbase[c] = d;
         end else begin
            p_dc = mbase[c] - d;
         end
         p_vld   = 1'b1;
         p_mode  = m;
         p_last  = lst;
         mcnt[c] = lst ? 0 : mcnt[c] + 1;
      end else if (v) begin
         p_err = 1'b1;
      end
      @(posedge clk);
      #1;
      exp_dc   = p_dc;
      exp_vld  = p_vld;
      exp_mode = p_mode;
      exp_last = p_last;
      exp_err  = p_err;
      frame_start = 1'b0;
      diff_valid  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_clear();
      exp_zero();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_clear();
      #1 rst = 1'b1;
      chk_en = 1'b1;
      do_reset();
      check("rst_dc_out", 32'(dc_out), 32'h0);
      check("rst_dc_mode", 32'(dc_mode), 32'h0);

      send(0, 1, 2'b01, 12'd100);
      check("y_a", 32'(dc_out), 32'd100);
      check("y_a_mode", 32'(dc_mode), 32'd1);
      send(0, 1, 2'b01, 12'd5);
      check("y_b", 32'(dc_out), 32'd95);
      send(0, 1, 2'b01, 12'hFEC);
      check("y_c", 32'(dc_out), 32'd120);
      send(0, 0, 2'b00, 12'd0);
      check("y_gap_valid", 32'(dc_valid), 32'd0);

      send(1, 0, 2'b00, 12'd0);
      check("fs_no_strobe", 32'(dc_valid), 32'd0);
      for (int i = 1; i <= BLOCKS; i++) begin
         send(0, 1, 2'b01, 12'(i));
         if (i == BLOCKS - 1)
            check("pre_last", 32'(dc_last), 32'd0);
      end
      check("last_flag", 32'(dc_last), 32'd1);
      check("last_dc", 32'(dc_out), 32'hFC1);
      send(0, 1, 2'b01, 12'd7);
      check("new_base", 32'(dc_out), 32'd7);
      check("new_base_last", 32'(dc_last), 32'd0);

      send(1, 1, 2'b01, 12'h7FF);
      send(0, 1, 2'b01, 12'h800);
      check("wrap", 32'(dc_out), 32'hFFF);

      send(1, 0, 2'b00, 12'd0);
      send(0, 1, 2'b01, 12'd10);
      check("il_y0", 32'(dc_out), 32'd10);
      send(0, 1, 2'b10, 12'd20);
      check("il_cr0", 32'(dc_out), 32'd20);
      send(0, 1, 2'b11, 12'd30);
      check("il_cb0", 32'(dc_out), 32'd30);
      send(0, 1, 2'b01, 12'd3);
      check("il_y1", 32'(dc_out), 32'd7);
      send(0, 1, 2'b10, 12'hFFC);
      check("il_cr1", 32'(dc_out), 32'd24);
      check("il_cr1_mode", 32'(dc_mode), 32'd2);
      send(0, 1, 2'b11, 12'd0);
      check("il_cb1", 32'(dc_out), 32'd30);
      check("il_cb1_mode", 32'(dc_mode), 32'd3);

      send(1, 1, 2'b10, 12'd50);
      check("fs_cr", 32'(dc_out), 32'd50);
      send(0, 1, 2'b01, 12'd9);
      check("fs_y", 32'(dc_out), 32'd9);

      send(0, 1, 2'b00, 12'd33);
      check("err_pulse", 32'(mode_err), 32'd1);
      check("err_no_vld", 32'(dc_valid), 32'd0);
      send(0, 0, 2'b00, 12'd0);
      check("err_one_cyc", 32'(mode_err), 32'd0);
      send(0, 1, 2'b01, 12'd1);
      check("err_keeps_y", 32'(dc_out), 32'd8);

      send(0, 1, 2'b10, 12'd5);
      #1;
      rst = 1'b1;
      model_clear();
      exp_zero();
      #1;
      check("arst_vld", 32'(dc_valid), 32'd0);
      check("arst_dc", 32'(dc_out), 32'd0);
      check("arst_mode", 32'(dc_mode), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      send(0, 1, 2'b10, 12'd5);
      check("arst_blk0", 32'(dc_out), 32'd5);
      send(0, 1, 2'b10, 12'd2);
      check("arst_blk1", 32'(dc_out), 32'd3);
      send(0, 0, 2'b00, 12'd0);
      send(0, 0, 2'b00, 12'd0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
